// File: rtl/pla_seq_eval.sv
// -----------------------------------------------------------------------------
// pla_seq_eval
// Programmable logic array evaluator. It has one product-term (cube) slot per
// table entry and evaluates one cube per clock. A cube matches an input vector
// v when ((v ^ val) & mask) == 0. The result y is the OR of the output bits of
// every matching cube.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   cfg_we/addr/mask/   cube-table write port. A write is accepted only while
//   val/out             cfg_ready is high. cfg_out == 0 disables the slot.
//   cfg_ready           high in IDLE
//   in_valid/in_ready/x input vector handshake
//   out_valid/out_ready result handshake
//   y                   result. It is held at 0 while out_valid is low.
//
// Build option
//   PLA_EARLY_EXIT_EN   When this is defined, EVAL moves to DONE on the cycle
//                       after the accumulator becomes all-ones, so the later
//                       cubes are not visited. The result y is unchanged;
//                       only the latency is shorter.
// -----------------------------------------------------------------------------
module pla_seq_eval #(
  parameter int NIN   = 9,
  parameter int NOUT  = 1,
  parameter int NCUBE = 8,
  localparam int AW   = (NCUBE > 1) ? $clog2(NCUBE) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [NIN-1:0]  cfg_mask,
  input  logic [NIN-1:0]  cfg_val,
  input  logic [NOUT-1:0] cfg_out,
  output logic            cfg_ready,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NIN-1:0]  x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NOUT-1:0] y
);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [NIN-1:0]  r_x;
  logic [NOUT-1:0] r_acc;
  logic [AW-1:0]   r_idx;

  logic [NIN-1:0]  r_mask [NCUBE];
  logic [NIN-1:0]  r_val  [NCUBE];
  logic [NOUT-1:0] r_out  [NCUBE];

  logic            w_cfg_wr;
  logic            w_hit;
  logic [NOUT-1:0] w_term;
  logic            w_last;
  logic            w_exit;

  // The table is written only in IDLE, and an address outside the table is
  // dropped. A write on the same edge that accepts a vector lands before the
  // first cube is read on the next cycle.
  assign w_cfg_wr = cfg_we && (r_state == IDLE) && (32'(cfg_addr) < NCUBE);

  assign w_hit  = (((r_x ^ r_val[r_idx]) & r_mask[r_idx]) == '0);
  assign w_term = w_hit ? r_out[r_idx] : '0;
  assign w_last = (r_idx == AW'(NCUBE - 1));

`ifdef PLA_EARLY_EXIT_EN
  // Once every output bit is set, no further cube can change the result.
  assign w_exit = w_last || (&r_acc);
`else
  assign w_exit = w_last;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // FSM next-state logic and handshake outputs
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    cfg_ready    = 1'b0;
    out_valid    = 1'b0;
    y            = '0;
    case (r_state)
      IDLE: begin
        in_ready  = 1'b1;
        cfg_ready = 1'b1;
        if (in_valid) w_state_next = EVAL;
      end
      EVAL: begin
        if (w_exit) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        y         = r_acc;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Evaluation datapath. x is captured at acceptance, so later changes on
  // the x input do not affect the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x   <= '0;
      r_acc <= '0;
      r_idx <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_x   <= x;
          r_acc <= '0;
          r_idx <= '0;
        end
        EVAL: begin
          r_acc <= r_acc | w_term;
          r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The cube output bits are reset, which disables every slot. The mask and
  // value arrays are not reset.
  generate
    for (genvar gi = 0; gi < NCUBE; gi++) begin : g_out
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                                        r_out[gi] <= '0;
        else if (w_cfg_wr && (cfg_addr == AW'(gi)))     r_out[gi] <= cfg_out;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_cfg_wr) begin
      r_mask[cfg_addr] <= cfg_mask;
      r_val[cfg_addr]  <= cfg_val;
    end
  end

endmodule

// File: tb/tb_pla_seq_eval.sv
module tb_pla_seq_eval;

  localparam int NIN   = 9;
  localparam int NOUT  = 1;
  localparam int NCUBE = 8;
  localparam int AW    = (NCUBE > 1) ? $clog2(NCUBE) : 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_we = 1'b0;
  logic [AW-1:0]   cfg_addr = '0;
  logic [NIN-1:0]  cfg_mask = '0;
  logic [NIN-1:0]  cfg_val = '0;
  logic [NOUT-1:0] cfg_out = '0;
  logic            cfg_ready;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [NIN-1:0]  x = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [NOUT-1:0] y;

  int checks = 0;
  int errors = 0;

  // Reference table
  logic [NIN-1:0]  m_mask [NCUBE];
  logic [NIN-1:0]  m_val  [NCUBE];
  logic [NOUT-1:0] m_out  [NCUBE];

  pla_seq_eval #(.NIN(NIN), .NOUT(NOUT), .NCUBE(NCUBE)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mask(cfg_mask),
    .cfg_val(cfg_val), .cfg_out(cfg_out), .cfg_ready(cfg_ready),
    .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .y(y)
  );

  always #5 clk = ~clk;

  function automatic logic [NOUT-1:0] model_y(input logic [NIN-1:0] v);
    logic [NOUT-1:0] r = '0;
    for (int k = 0; k < NCUBE; k++)
      if (((v ^ m_val[k]) & m_mask[k]) == '0) r = r | m_out[k];
    return r;
  endfunction

  function automatic int model_lat(input logic [NIN-1:0] v);
`ifdef PLA_EARLY_EXIT_EN
    logic [NOUT-1:0] r = '0;
    for (int k = 0; k < NCUBE; k++) begin
      if (((v ^ m_val[k]) & m_mask[k]) == '0) r = r | m_out[k];
      if (&r) return (k + 2 < NCUBE) ? k + 2 : NCUBE;
    end
`endif
    return NCUBE;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < NCUBE; k++) m_out[k] = '0;
  endfunction

  // Writes one table entry. The caller makes sure the DUT is in IDLE.
  task automatic write_cfg(input int a, input logic [NIN-1:0] mk,
                           input logic [NIN-1:0] vl, input logic [NOUT-1:0] o);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_mask = mk; cfg_val = vl; cfg_out = o;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_mask[a] = mk; m_val[a] = vl; m_out[a] = o;
  endtask

  // Offers v and waits for out_valid. It returns y, the latency in cycles,
  // whether y was non-zero while out_valid was low, and whether the wait
  // timed out. x is scrambled after acceptance.
  task automatic run_vec(input logic [NIN-1:0] v, input bit finish,
                         output logic [NOUT-1:0] yo, output int lat,
                         output bit leak, output bit timeout);
    leak = 1'b0; timeout = 1'b1; lat = 0; yo = '0;
    @(negedge clk);
    x = v; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; x = NIN'($urandom);
    for (int c = 1; c <= 200; c++) begin
      if (!out_valid && (y !== '0)) leak = 1'b1;
      @(posedge clk); #1;
      if (out_valid) begin lat = c; timeout = 1'b0; break; end
    end
    @(negedge clk);
    yo = y;
    if (finish) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || y !== '0 || in_ready !== 1'b1 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: out_valid=%b y=%h in_ready=%b cfg_ready=%b, required 0 0 1 1",
               out_valid, y, in_ready, cfg_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    $display("reset released");
  endtask

  task automatic check_vec(input string name, input logic [NIN-1:0] v);
    logic [NOUT-1:0] yo; int lat; bit leak, to;
    logic [NOUT-1:0] ey; int el;
    ey = model_y(v); el = model_lat(v);
    run_vec(v, 1'b1, yo, lat, leak, to);
    $display("%s: x=%h y=%h lat=%0d (expect y=%h lat=%0d)", name, v, yo, lat, ey, el);
    checks++;
    if (to) begin errors++; $display("FAIL %s timeout: out_valid never rose", name); end
    checks++;
    if (yo !== ey) begin errors++; $display("FAIL %s y: got %h required %h", name, yo, ey); end
    checks++;
    if (lat != el) begin errors++; $display("FAIL %s latency: got %0d required %0d", name, lat, el); end
    checks++;
    if (leak) begin errors++; $display("FAIL %s y_gate: y non-zero while out_valid low, required 0", name); end
  endtask

  task automatic test_empty();
    model_clear();
    check_vec("empty", 9'h1FF);
  endtask

  task automatic test_slot0();
    write_cfg(0, 9'h1C4, 9'h144, 1'b1);
    check_vec("slot0_hit", 9'h144);
    check_vec("slot0_miss", 9'h1C4);
  endtask

  task automatic test_slot5();
    write_cfg(5, 9'h0C5, 9'h005, 1'b1);
    check_vec("slot5_hit", 9'h005);
    check_vec("slot5_miss", 9'h000);
  endtask

  task automatic test_hold();
    logic [NOUT-1:0] yo; int lat; bit leak, to;
    logic [NOUT-1:0] ey;
    ey = model_y(9'h144);
    run_vec(9'h144, 1'b0, yo, lat, leak, to);
    checks++;
    if (to || yo !== ey) begin
      errors++; $display("FAIL hold_first: y=%h timeout=%b, required y=%h", yo, to, ey);
    end
    // While DONE is held, try to disable slot 0. The write must be ignored.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = '0; cfg_mask = '0; cfg_val = '0; cfg_out = '0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || y !== ey || in_ready !== 1'b0 || cfg_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold cycle %0d: out_valid=%b y=%h in_ready=%b cfg_ready=%b, required 1 %h 0 0",
                 c, out_valid, y, in_ready, cfg_ready, ey);
      end
    end
    @(negedge clk); cfg_we = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || y !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: out_valid=%b y=%h in_ready=%b, required 0 0 1", out_valid, y, in_ready);
    end
    $display("hold: 10 stalled cycles, released");
    check_vec("hold_readback", 9'h144);
  endtask

  task automatic test_same_edge();
    logic [NOUT-1:0] yo; int lat; bit leak, to;
    logic [NOUT-1:0] ey;
    m_mask[3] = 9'h1FF; m_val[3] = 9'h0AB; m_out[3] = 1'b1;
    ey = model_y(9'h0AB);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = AW'(3); cfg_mask = 9'h1FF; cfg_val = 9'h0AB; cfg_out = 1'b1;
    x = 9'h0AB; in_valid = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0; x = NIN'($urandom);
    to = 1'b1; yo = '0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin to = 1'b0; lat = c; break; end
    end
    yo = y;
    $display("same_edge: y=%h (expect %h)", yo, ey);
    checks++;
    if (to || yo !== ey) begin
      errors++; $display("FAIL same_edge: y=%h timeout=%b, required y=%h", yo, to, ey);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [NIN-1:0] v;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(1, 0) == 1)
        write_cfg(int'($urandom_range(NCUBE - 1, 0)), NIN'($urandom), NIN'($urandom),
                  NOUT'($urandom_range(3, 0) != 0));
      // About half the vectors are steered toward some slot's literals.
      v = NIN'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        int k = int'($urandom_range(NCUBE - 1, 0));
        v = (v & ~m_mask[k]) | (m_val[k] & m_mask[k]);
      end
      check_vec($sformatf("rand%0d", i), v);
    end
  endtask

  task automatic test_midreset();
    bit rose = 1'b0;
    @(negedge clk);
    x = 9'h144; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_async: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    @(negedge clk); rst = 1'b0;
    model_clear();
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid) rose = 1'b1;
    end
    checks++;
    if (rose || in_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_abort: out_valid rose=%b in_ready=%b, required 0 1", rose, in_ready);
    end
    $display("midreset: aborted at index 3");
    check_vec("post_reset", 9'h144);
  endtask

  initial begin
    for (int k = 0; k < NCUBE; k++) begin m_mask[k] = '0; m_val[k] = '0; m_out[k] = '0; end
    test_reset();
    test_empty();
    test_slot0();
    test_slot5();
    test_hold();
    test_same_edge();
    test_random();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pla_seq_eval.md
PLA_SEQ_EVAL -- requirements
Module: pla_seq_eval

Interface
REQ-001 Parameter NIN, default 9, number of PLA inputs (1..32).
REQ-002 Parameter NOUT, default 1, number of PLA outputs (1..16).
REQ-003 Parameter NCUBE, default 8, number of product-term (cube) slots (2..64); AW = clog2(NCUBE).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 cfg_we  input  1  cube-table write strobe.
REQ-007 cfg_addr  input  AW  cube slot index.
REQ-008 cfg_mask  input  NIN  care bits; 1 = input participates in cube.
REQ-009 cfg_val  input  NIN  required literal polarity for cared inputs.
REQ-010 cfg_out  input  NOUT  outputs driven by cube; all-zero = slot disabled.
REQ-011 cfg_ready  output  1  high when table writes are accepted.
REQ-012 in_valid  input  1  input vector offered.
REQ-013 in_ready  output  1  evaluator can accept a vector.
REQ-014 x  input  NIN  input vector.
REQ-015 out_valid  output  1  result y is valid.
REQ-016 out_ready  input  1  consumer accepts result.
REQ-017 y  output  NOUT  registered sum-of-products result.

Function
REQ-018 Cube k SHALL match vector v iff ((v ^ val[k]) & mask[k]) == 0; y SHALL be the bitwise OR of out[k] over all matching k.
REQ-019 FSM states SHALL be IDLE, EVAL, DONE; in_ready = cfg_ready = (state == IDLE).
REQ-020 IDLE: in_valid & in_ready SHALL latch x, clear accumulator, set index 0, go to EVAL.
REQ-021 EVAL: one cube per cycle, index ascending; after index NCUBE-1 SHALL go to DONE, so out_valid rises exactly NCUBE cycles after the accepting edge.
REQ-022 DONE: out_valid = 1, y = accumulator; y and out_valid SHALL hold stable until out_valid & out_ready, then go to IDLE (out_valid low next cycle).
REQ-023 in_ready SHALL be low in EVAL and DONE; no new vector accepted until the result handshake completes.
REQ-024 cfg_we & cfg_ready SHALL write slot cfg_addr at the edge; cfg_we while cfg_ready low SHALL be ignored with no table change.
REQ-025 cfg_addr >= NCUBE SHALL be ignored.
REQ-026 A table write and vector accept on the same IDLE edge: the write SHALL complete first-edge and the following evaluation SHALL use the new contents.
REQ-027 x changes after acceptance SHALL not affect the result.
REQ-028 y SHALL be 0 whenever out_valid is 0.

Reset
REQ-029 rst SHALL asynchronously force state IDLE, out_valid 0, y 0, accumulator 0, index 0.
REQ-030 rst SHALL clear every cfg_out slot to 0 (all cubes disabled); mask/val contents need not reset.
REQ-031 rst asserted mid-EVAL or in DONE SHALL abort the evaluation with no result emitted.

Configuration
REQ-032 Macro PLA_EARLY_EXIT_EN: when defined, EVAL SHALL go to DONE on the cycle after the accumulator becomes all-ones or after index NCUBE-1, whichever first; when undefined, latency is always exactly NCUBE cycles (REQ-021).
REQ-033 Result y SHALL be identical with and without PLA_EARLY_EXIT_EN; only latency differs.

Verification
REQ-034 After reset, NIN=9, NOUT=1, NCUBE=8, no writes; send x=9'h1FF -> out_valid after 8 cycles, y=0.
REQ-035 Program slot 0 mask=9'h1C4 val=9'h144 out=1 (x2 & x6 & ~x7 & x8); x=9'h144 -> y=1; x=9'h1C4 -> y=0.
REQ-036 Add slot 5 mask=9'h0C5 val=9'h005 out=1 (x0 & x2 & ~x6 & ~x7); x=9'h005 -> y=1 via slot 5; x=9'h000 -> y=0.
REQ-037 Hold out_ready=0 for 10 cycles in DONE -> y, out_valid stable, in_ready=0, cfg_we ignored (table readback via later evaluation unchanged).
REQ-038 With PLA_EARLY_EXIT_EN, slot 0 out=1 matching x=9'h144 -> out_valid 2 cycles after accept, y=1; without macro -> 8 cycles, y=1.
REQ-039 Assert rst at EVAL index 3 -> out_valid never rises, in_ready=1 after release, all slots disabled (next vector -> y=0).
